// File: rtl/decode_execute_register.sv
// ID/EX pipeline register: captures decode operands/control, inserts bubbles on stall or flush,
// holds on freeze, and counts inserted bubbles and frozen cycles.
module decode_execute_register #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned COUNTER_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     isPipelineFrozen,
  input  logic                     isPipelineStalled,
  input  logic                     isFlush,
  input  logic                     decodeValid,
  input  logic [XLEN-1:0]          decodePc,
  input  logic [XLEN-1:0]          decodeLHSData,
  input  logic [XLEN-1:0]          decodeRHSData,
  input  logic [XLEN-1:0]          decodeImmediate,
  input  logic [4:0]               decodeLHSReadRegisterIndex,
  input  logic [4:0]               decodeRHSReadRegisterIndex,
  input  logic [4:0]               decodeWriteRegisterIndex,
  input  logic [9:0]               decodeControl,
  output logic                     executionValid,
  output logic [XLEN-1:0]          executionPc,
  output logic [XLEN-1:0]          executionLHSData,
  output logic [XLEN-1:0]          executionRHSData,
  output logic [XLEN-1:0]          executionImmediate,
  output logic [4:0]               executionLHSReadRegisterIndex,
  output logic [4:0]               executionRHSReadRegisterIndex,
  output logic [4:0]               executionStageWriteRegisterIndex,
  output logic [9:0]               executionControl,
  output logic                     isExecutionStageMemoryReadOperation,
  output logic [COUNTER_WIDTH-1:0] bubbleCount,
  output logic [COUNTER_WIDTH-1:0] frozenCount
);

  localparam int unsigned MemReadBit = 8;

  logic                     r_valid;
  logic [XLEN-1:0]          r_pc;
  logic [XLEN-1:0]          r_lhs_data;
  logic [XLEN-1:0]          r_rhs_data;
  logic [XLEN-1:0]          r_immediate;
  logic [4:0]               r_lhs_index;
  logic [4:0]               r_rhs_index;
  logic [4:0]               r_rd_index;
  logic [9:0]               r_control;
  logic [COUNTER_WIDTH-1:0] r_bubble_count;
  logic [COUNTER_WIDTH-1:0] r_frozen_count;

  logic w_bubble;
  logic w_capture;

  assign w_bubble  = !isPipelineFrozen && (isFlush || isPipelineStalled);
  // An invalid decode slot is loaded as an all-zero bubble so no stale control leaks through.
  assign w_capture = !isPipelineFrozen && !w_bubble && decodeValid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_lhs_data  <= '0;
      r_rhs_data  <= '0;
      r_immediate <= '0;
      r_lhs_index <= '0;
      r_rhs_index <= '0;
      r_rd_index  <= '0;
      r_control   <= '0;
    end else if (!isPipelineFrozen) begin
      r_valid     <= w_capture;
      r_pc        <= w_capture ? decodePc : '0;
      r_lhs_data  <= w_capture ? decodeLHSData : '0;
      r_rhs_data  <= w_capture ? decodeRHSData : '0;
      r_immediate <= w_capture ? decodeImmediate : '0;
      r_lhs_index <= w_capture ? decodeLHSReadRegisterIndex : '0;
      r_rhs_index <= w_capture ? decodeRHSReadRegisterIndex : '0;
      r_rd_index  <= w_capture ? decodeWriteRegisterIndex : '0;
      r_control   <= w_capture ? decodeControl : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_count <= '0;
      r_frozen_count <= '0;
    end else begin
      if (isPipelineFrozen) begin
        r_frozen_count <= r_frozen_count + COUNTER_WIDTH'(1);
      end
      if (w_bubble) begin
        r_bubble_count <= r_bubble_count + COUNTER_WIDTH'(1);
      end
    end
  end

  assign executionValid                      = r_valid;
  assign executionPc                         = r_pc;
  assign executionLHSData                    = r_lhs_data;
  assign executionRHSData                    = r_rhs_data;
  assign executionImmediate                  = r_immediate;
  assign executionLHSReadRegisterIndex       = r_lhs_index;
  assign executionRHSReadRegisterIndex       = r_rhs_index;
  assign executionStageWriteRegisterIndex    = r_rd_index;
  assign executionControl                    = r_control;
  // Gated by valid so a bubble can never re-trigger the load-use stall.
  assign isExecutionStageMemoryReadOperation = r_valid && r_control[MemReadBit];
  assign bubbleCount                         = r_bubble_count;
  assign frozenCount                         = r_frozen_count;

endmodule

// File: tb/tb_decode_execute_register.sv
// Bench for decode_execute_register: directed scenarios plus randomized traffic checked every
// cycle against a rule-level model of the ID/EX register.
module tb_decode_execute_register;

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            frz, stl, fls, dvalid;
  logic [XLEN-1:0] dpc, dlhs, drhs, dimm;
  logic [4:0]      drs1, drs2, drd;
  logic [9:0]      dctrl;

  logic            evalid;
  logic [XLEN-1:0] epc, elhs, erhs, eimm;
  logic [4:0]      ers1, ers2, erd;
  logic [9:0]      ectrl;
  logic            ememrd;
  logic [CW-1:0]   bcnt, fcnt;

  decode_execute_register #(
    .XLEN         (XLEN),
    .COUNTER_WIDTH(CW)
  ) dut (
    .clk                                (clk),
    .rst_n                              (rst_n),
    .isPipelineFrozen                   (frz),
    .isPipelineStalled                  (stl),
    .isFlush                            (fls),
    .decodeValid                        (dvalid),
    .decodePc                           (dpc),
    .decodeLHSData                      (dlhs),
    .decodeRHSData                      (drhs),
    .decodeImmediate                    (dimm),
    .decodeLHSReadRegisterIndex         (drs1),
    .decodeRHSReadRegisterIndex         (drs2),
    .decodeWriteRegisterIndex           (drd),
    .decodeControl                      (dctrl),
    .executionValid                     (evalid),
    .executionPc                        (epc),
    .executionLHSData                   (elhs),
    .executionRHSData                   (erhs),
    .executionImmediate                 (eimm),
    .executionLHSReadRegisterIndex      (ers1),
    .executionRHSReadRegisterIndex      (ers2),
    .executionStageWriteRegisterIndex   (erd),
    .executionControl                   (ectrl),
    .isExecutionStageMemoryReadOperation(ememrd),
    .bubbleCount                        (bcnt),
    .frozenCount                        (fcnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  // Model state: what the execute stage must hold, plus counters as plain integers.
  typedef struct {
    bit       valid;
    int unsigned pc, lhs, rhs, imm;
    int unsigned rs1, rs2, rd, ctrl;
  } slot_t;

  slot_t       m_slot;
  int unsigned m_bubbles;
  int unsigned m_frozen;
  localparam slot_t EmptySlot = '{valid: 1'b0, pc: 0, lhs: 0, rhs: 0, imm: 0,
                                  rs1: 0, rs2: 0, rd: 0, ctrl: 0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge rst_n) begin
    m_slot    = EmptySlot;
    m_bubbles = 0;
    m_frozen  = 0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_slot    = EmptySlot;
      m_bubbles = 0;
      m_frozen  = 0;
    end else if (frz) begin
      m_frozen = (m_frozen + 1) % (1 << CW);
    end else if (fls || stl) begin
      m_slot    = EmptySlot;
      m_bubbles = (m_bubbles + 1) % (1 << CW);
    end else if (!dvalid) begin
      m_slot = EmptySlot;
    end else begin
      m_slot = '{valid: 1'b1, pc: dpc, lhs: dlhs, rhs: drhs, imm: dimm,
                 rs1: drs1, rs2: drs2, rd: drd, ctrl: dctrl};
    end
  end

  task automatic compare_all();
    bit exp_memrd;
    exp_memrd = m_slot.valid && ((m_slot.ctrl >> 8) & 1) == 1;
    chk("valid", evalid, m_slot.valid);
    chk("pc", epc, m_slot.pc);
    chk("lhs", elhs, m_slot.lhs);
    chk("rhs", erhs, m_slot.rhs);
    chk("imm", eimm, m_slot.imm);
    chk("rs1", ers1, m_slot.rs1);
    chk("rs2", ers2, m_slot.rs2);
    chk("rd", erd, m_slot.rd);
    chk("ctrl", ectrl, m_slot.ctrl);
    chk("memrd", ememrd, exp_memrd);
    chk("bubbleCount", bcnt, m_bubbles);
    chk("frozenCount", fcnt, m_frozen);
  endtask

  always @(negedge clk) begin
    if (check_en) compare_all();
  end

  task automatic idle_inputs();
    frz = 0; stl = 0; fls = 0; dvalid = 0;
    dpc = 0; dlhs = 0; drhs = 0; dimm = 0;
    drs1 = 0; drs2 = 0; drd = 0; dctrl = 0;
  endtask

  task automatic edge_then_settle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #4 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", evalid, 1'b0);
    chk("reset_bubble", bcnt, 4'd0);
    #6 rst_n = 1'b1;
    check_en = 1'b1;

    // Load a memory-read instruction.
    @(posedge clk); #1;
    dvalid = 1; dpc = 32'h40; drd = 5; drs1 = 3; drs2 = 4; dctrl = 10'h100;
    dlhs = 32'h1111; drhs = 32'h2222; dimm = 32'hFFFF_FFF0;
    edge_then_settle();
    chk("load_pc", epc, 32'h40);
    chk("load_rd", erd, 5'd5);
    chk("load_memrd", ememrd, 1'b1);

    // Single load-use stall cycle, then a normal load.
    stl = 1;
    edge_then_settle();
    chk("stall_valid", evalid, 1'b0);
    chk("stall_ctrl", ectrl, 10'h0);
    chk("stall_rd", erd, 5'd0);
    chk("stall_memrd", ememrd, 1'b0);
    chk("stall_bubble", bcnt, 4'd1);
    stl = 0;
    edge_then_settle();
    chk("reload_valid", evalid, 1'b1);
    chk("reload_pc", epc, 32'h40);

    // Freeze beats flush for three cycles.
    frz = 1; fls = 1; dpc = 32'h80; drd = 9;
    repeat (3) edge_then_settle();
    chk("freeze_count", fcnt, 4'd3);
    chk("freeze_bubble", bcnt, 4'd1);
    chk("freeze_pc", epc, 32'h40);
    chk("freeze_rd", erd, 5'd5);
    frz = 0; fls = 0;
    edge_then_settle();
    chk("after_freeze_pc", epc, 32'h80);

    // Flush and stall together count as one bubble.
    fls = 1; stl = 1;
    edge_then_settle();
    chk("dual_bubble", bcnt, 4'd2);
    chk("dual_valid", evalid, 1'b0);
    fls = 0; stl = 0;
    edge_then_settle();
    chk("pre_reset_valid", evalid, 1'b1);

    // Asynchronous reset mid-cycle.
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", evalid, 1'b0);
    chk("async_pc", epc, 32'h0);
    chk("async_bubble", bcnt, 4'd0);
    chk("async_frozen", fcnt, 4'd0);
    #2 rst_n = 1'b1;

    // Seventeen flushes wrap a 4-bit counter to 1.
    @(posedge clk); #1;
    fls = 1;
    repeat (17) edge_then_settle();
    chk("wrap_bubble", bcnt, 4'd1);
    fls = 0;

    // Randomized traffic, including rd=0 and invalid decode with junk control.
    for (int i = 0; i < 3000; i++) begin
      frz    = ($urandom_range(0, 4) == 0);
      stl    = ($urandom_range(0, 5) == 0);
      fls    = ($urandom_range(0, 5) == 0);
      dvalid = ($urandom_range(0, 3) != 0);
      dpc    = $urandom; dlhs = $urandom; drhs = $urandom; dimm = $urandom;
      drs1   = 5'($urandom); drs2 = 5'($urandom);
      drd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      dctrl  = 10'($urandom);
      if ($urandom_range(0, 299) == 0) pulse_reset();
      edge_then_settle();
    end

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
